// File: rtl/bcd_conv_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_conv_scheduler
//  Purpose  : Round-robin scheduler sharing one sequential binary-to-BCD
//             converter among NREQ requesters. It accepts one operand per
//             grant, starts the converter and waits for done or a timeout.
//             It then returns the BCD result as a one-cycle response pulse.
//  Options  : BCD_SCHED_RANGE_CHECK_EN - operands above 10^NDECS-1 skip the
//             converter and return all-nines with rsp_err set.
//  Revision : 1.0  initial release
// ============================================================================
module bcd_conv_scheduler #(
    parameter int NREQ    = 4,
    parameter int NBITS   = 8,
    parameter int NDECS   = 3,
    parameter int TIMEOUT = 64
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*NBITS-1:0] req_bin,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [NDECS*4-1:0]    rsp_dec,
    output logic                  rsp_err,
    output logic                  conv_start,
    output logic [NBITS-1:0]      conv_bin,
    input  logic                  conv_done,
    input  logic [NDECS*4-1:0]    conv_dec,
    output logic                  busy
);

    localparam int DEC_BITS = NDECS * 4;
    localparam int PTR_W    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NREQ - 1);
    localparam logic [NREQ-1:0]  ONE_HOT0 = NREQ'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARB   = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [PTR_W-1:0]     ptr;
    logic [PTR_W-1:0]     grant;
    logic [CNT_W-1:0]     cnt;
    logic                 found;
    logic [PTR_W-1:0]     pick;
    logic [NBITS-1:0]     pick_bin;
    logic                 too_big;

    // Round-robin search: first valid requester at or after the pointer.
    always_comb begin
        int cand;
        cand  = 0;
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (int'(ptr) + k) % NREQ;
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                pick  = PTR_W'(cand);
            end
        end
    end

    assign pick_bin = req_bin[int'(pick)*NBITS +: NBITS];

`ifdef BCD_SCHED_RANGE_CHECK_EN
    // Largest value representable in NDECS decimal digits.
    localparam logic [63:0] MAX_DEC = 64'(10**NDECS - 1);
    assign too_big = (64'(pick_bin) > MAX_DEC);
`else
    assign too_big = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next-state decode and handshake/strobe outputs.
    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        rsp_valid  = '0;
        conv_start = 1'b0;
        busy       = (state != S_IDLE);
        case (state)
            S_IDLE:  if (|req_valid) state_nxt = S_ARB;
            S_ARB: begin
                if (!found) begin
                    state_nxt = S_IDLE;
                end else begin
                    req_ready = ONE_HOT0 << pick;
                    state_nxt = too_big ? S_RESP : S_START;
                end
            end
            S_START: begin
                conv_start = 1'b1;
                state_nxt  = S_WAIT;
            end
            // Done has priority over the timeout in the same cycle.
            S_WAIT:  if (conv_done || (cnt == CNT_LAST)) state_nxt = S_RESP;
            S_RESP: begin
                rsp_valid = ONE_HOT0 << grant;
                state_nxt = (|req_valid) ? S_ARB : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: operand capture, pointer advance, timeout counter, result.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr      <= '0;
            grant    <= '0;
            cnt      <= '0;
            conv_bin <= '0;
            rsp_dec  <= '0;
            rsp_err  <= 1'b0;
        end else begin
            case (state)
                S_ARB: begin
                    if (found) begin
                        conv_bin <= pick_bin;
                        grant    <= pick;
                        ptr      <= (pick == PTR_LAST) ? '0 : pick + 1'b1;
                        if (too_big) begin
                            rsp_dec <= {NDECS{4'h9}};
                            rsp_err <= 1'b1;
                        end
                    end
                end
                S_START: cnt <= '0;
                S_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (conv_done) begin
                        rsp_dec <= conv_dec;
                        rsp_err <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        rsp_dec <= '0;
                        rsp_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bcd_conv_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_conv_scheduler
//  Purpose  : Directed self-checking bench for bcd_conv_scheduler with a
//             behavioural converter model (programmable done delay).
//  Revision : 1.0  initial release
// ============================================================================
module tb_bcd_conv_scheduler;

    localparam int NREQ = 4;
    localparam int NB   = 10;

    logic              clock = 1'b0;
    logic              reset_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*NB-1:0] req_bin;
    logic [NREQ-1:0]   rsp_valid;
    logic [11:0]       rsp_dec;
    logic              rsp_err;
    logic              conv_start;
    logic [NB-1:0]     conv_bin;
    logic              conv_done;
    logic [11:0]       conv_dec;
    logic              busy;

    int n_tests = 0;
    int n_fail  = 0;

    // converter model controls
    logic model_en    = 1'b1;
    int   model_delay = 5;
    int   manual_req  = 0;

    bcd_conv_scheduler #(.NREQ(NREQ), .NBITS(NB), .NDECS(3), .TIMEOUT(64)) dut (
        .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_bin(req_bin), .rsp_valid(rsp_valid), .rsp_dec(rsp_dec), .rsp_err(rsp_err),
        .conv_start(conv_start), .conv_bin(conv_bin), .conv_done(conv_done),
        .conv_dec(conv_dec), .busy(busy)
    );

    always #5 clock = ~clock;

    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] r;
        int t;
        t = v;
        r = '0;
        for (int i = 0; i < 3; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Converter model: done pulse model_delay cycles after conv_start.
    initial begin
        int pend, mcnt, mbin, manual_ack;
        pend = 0; mcnt = 0; mbin = 0; manual_ack = 0;
        conv_done = 1'b0;
        conv_dec  = '0;
        forever begin
            @(posedge clock); #1;
            conv_done = 1'b0;
            if (manual_req != manual_ack) begin
                manual_ack = manual_req;
                conv_done  = 1'b1;
                conv_dec   = 12'h777;
            end else if (conv_start && model_en) begin
                pend = 1; mcnt = model_delay; mbin = int'(conv_bin);
            end else if (pend != 0) begin
                if (mcnt <= 1) begin
                    conv_done = 1'b1;
                    conv_dec  = to_bcd(mbin);
                    pend      = 0;
                end else begin
                    mcnt--;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        tick();
    endtask

    // Issue one request and follow it to its response cycle.
    task automatic do_request(input int idx, input int bin, output int rdy_wait,
                              output logic [NREQ-1:0] rdy, output int lat,
                              output logic started, output logic [NB-1:0] start_bin);
        req_bin[idx*NB +: NB] = NB'(bin);
        req_valid = NREQ'(1) << idx;
        rdy_wait = 0;
        rdy = '0;
        while (rdy == '0 && rdy_wait < 20) begin
            tick(); rdy_wait++; rdy = req_ready;
        end
        tick();
        req_valid = '0;
        started   = conv_start;
        start_bin = conv_bin;
        lat = 1;
        while (rsp_valid == '0 && lat < 200) begin
            tick(); lat++;
            if (conv_start) started = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req_valid = '0; req_bin = '0;
        tick(); tick();
        n_tests++; if ({req_ready, rsp_valid, rsp_dec, rsp_err, conv_start, conv_bin, busy} !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", {req_ready, rsp_valid, rsp_dec, rsp_err, conv_start, conv_bin, busy}); end
        reset_n = 1'b1;
        tick();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_single();
        int rw, lat; logic [NREQ-1:0] rdy; logic st; logic [NB-1:0] sb;
        model_en = 1'b1; model_delay = 20;
        do_request(2, 173, rw, rdy, lat, st, sb);
        n_tests++; if (rw !== 1) begin n_fail++; $display("FAIL single_ready_cycle: got %0d want 1", rw); end
        n_tests++; if (rdy !== 4'b0100) begin n_fail++; $display("FAIL single_ready: got %b want 0100", rdy); end
        n_tests++; if (st !== 1'b1 || sb !== 10'd173) begin n_fail++; $display("FAIL single_start: got start=%b bin=%0d want 1/173", st, sb); end
        n_tests++; if (lat !== 22) begin n_fail++; $display("FAIL single_latency: got %0d want 22", lat); end
        n_tests++; if (rsp_valid !== 4'b0100 || rsp_dec !== 12'h173 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL single_rsp: got v=%b d=%h e=%b want 0100/173/0", rsp_valid, rsp_dec, rsp_err); end
        tick();
        n_tests++; if (rsp_valid !== '0 || busy !== 1'b0 || rsp_dec !== 12'h173) begin n_fail++; $display("FAIL single_after: got v=%b busy=%b d=%h want 0/0/173", rsp_valid, busy, rsp_dec); end
    endtask

    task automatic test_fairness();
        int k, w;
        apply_reset();
        model_delay = 3;
        for (int i = 0; i < NREQ; i++) req_bin[i*NB +: NB] = NB'(i + 1);
        req_valid = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            w = g % NREQ;
            k = 0;
            do begin tick(); k++; end while (req_ready == '0 && k < 20);
            n_tests++; if (req_ready !== (NREQ'(1) << w)) begin n_fail++; $display("FAIL fair_grant%0d: got %b want %b", g, req_ready, NREQ'(1) << w); end
            k = 0;
            do begin tick(); k++; end while (rsp_valid == '0 && k < 100);
            n_tests++; if (rsp_valid !== (NREQ'(1) << w) || rsp_dec !== to_bcd(w + 1)) begin n_fail++; $display("FAIL fair_rsp%0d: got v=%b d=%h want %b/%h", g, rsp_valid, rsp_dec, NREQ'(1) << w, to_bcd(w + 1)); end
        end
        req_valid = '0;
        tick();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fair_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_timeout();
        int rw, lat; logic [NREQ-1:0] rdy; logic st; logic [NB-1:0] sb;
        model_en = 1'b0;
        do_request(0, 99, rw, rdy, lat, st, sb);
        n_tests++; if (lat !== 66) begin n_fail++; $display("FAIL timeout_latency: got %0d want 66", lat); end
        n_tests++; if (rsp_valid !== 4'b0001 || rsp_err !== 1'b1 || rsp_dec !== 12'h000) begin n_fail++; $display("FAIL timeout_rsp: got v=%b e=%b d=%h want 0001/1/000", rsp_valid, rsp_err, rsp_dec); end
        model_en = 1'b1; model_delay = 5;
        do_request(1, 42, rw, rdy, lat, st, sb);
        n_tests++; if (lat !== 7 || rsp_valid !== 4'b0010 || rsp_err !== 1'b0 || rsp_dec !== 12'h042) begin n_fail++; $display("FAIL after_timeout: got lat=%0d v=%b e=%b d=%h want 7/0010/0/042", lat, rsp_valid, rsp_err, rsp_dec); end
        model_delay = 65;
        do_request(3, 500, rw, rdy, lat, st, sb);
        n_tests++; if (lat !== 66 || rsp_err !== 1'b1 || rsp_dec !== 12'h000) begin n_fail++; $display("FAIL late_done: got lat=%0d e=%b d=%h want 66/1/000", lat, rsp_err, rsp_dec); end
        tick();
        n_tests++; if (busy !== 1'b0 || rsp_valid !== '0) begin n_fail++; $display("FAIL late_done_ignored: got busy=%b v=%b want 0/0", busy, rsp_valid); end
    endtask

    task automatic test_coincide();
        int rw, lat; logic [NREQ-1:0] rdy; logic st; logic [NB-1:0] sb;
        model_delay = 64;
        do_request(2, 255, rw, rdy, lat, st, sb);
        n_tests++; if (lat !== 66 || rsp_err !== 1'b0 || rsp_dec !== 12'h255) begin n_fail++; $display("FAIL coincide: got lat=%0d e=%b d=%h want 66/0/255", lat, rsp_err, rsp_dec); end
    endtask

    task automatic test_reset_mid();
        int k; logic saw_rsp, saw_busy;
        model_delay = 20;
        req_bin[2*NB +: NB] = NB'(7);
        req_valid = 4'b0100;
        k = 0;
        do begin tick(); k++; end while (req_ready == '0 && k < 20);
        tick(); req_valid = '0;
        for (int i = 0; i < 5; i++) tick();
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midreset_busy_before: got %b want 1", busy); end
        reset_n = 1'b0;
        #1;
        n_tests++; if ({req_ready, rsp_valid, rsp_dec, rsp_err, conv_start, conv_bin, busy} !== '0) begin n_fail++; $display("FAIL midreset_outputs: got %h want 0", {req_ready, rsp_valid, rsp_dec, rsp_err, conv_start, conv_bin, busy}); end
        tick();
        reset_n = 1'b1;
        manual_req++;
        saw_rsp = 1'b0; saw_busy = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (rsp_valid != '0) saw_rsp = 1'b1;
            if (busy) saw_busy = 1'b1;
        end
        n_tests++; if (saw_rsp !== 1'b0 || saw_busy !== 1'b0 || rsp_dec !== 12'h000) begin n_fail++; $display("FAIL midreset_done_ignored: got rsp=%b busy=%b d=%h want 0/0/000", saw_rsp, saw_busy, rsp_dec); end
        // pointer must be back at 0: requesters 0 and 3 together -> 0 first
        model_delay = 4;
        req_bin[0 +: NB] = NB'(5);
        req_bin[3*NB +: NB] = NB'(6);
        req_valid = 4'b1001;
        tick();
        n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL midreset_pointer: got %b want 0001", req_ready); end
        tick(); req_valid = 4'b1000;
        k = 0;
        do begin tick(); k++; end while (rsp_valid == '0 && k < 100);
        n_tests++; if (rsp_valid !== 4'b0001 || rsp_dec !== 12'h005) begin n_fail++; $display("FAIL midreset_rsp0: got v=%b d=%h want 0001/005", rsp_valid, rsp_dec); end
        tick();
        n_tests++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL back_to_back_grant: got %b want 1000", req_ready); end
        tick(); req_valid = '0;
        k = 0;
        do begin tick(); k++; end while (rsp_valid == '0 && k < 100);
        n_tests++; if (rsp_valid !== 4'b1000 || rsp_dec !== 12'h006) begin n_fail++; $display("FAIL back_to_back_rsp: got v=%b d=%h want 1000/006", rsp_valid, rsp_dec); end
    endtask

    task automatic test_range();
        int rw, lat; logic [NREQ-1:0] rdy; logic st; logic [NB-1:0] sb;
        model_delay = 5;
        do_request(1, 1000, rw, rdy, lat, st, sb);
`ifdef BCD_SCHED_RANGE_CHECK_EN
        n_tests++; if (st !== 1'b0 || lat !== 1) begin n_fail++; $display("FAIL range_skip: got start=%b lat=%0d want 0/1", st, lat); end
        n_tests++; if (rsp_valid !== 4'b0010 || rsp_err !== 1'b1 || rsp_dec !== 12'h999) begin n_fail++; $display("FAIL range_rsp: got v=%b e=%b d=%h want 0010/1/999", rsp_valid, rsp_err, rsp_dec); end
`else
        n_tests++; if (st !== 1'b1 || lat !== 7) begin n_fail++; $display("FAIL range_nocheck_start: got start=%b lat=%0d want 1/7", st, lat); end
        n_tests++; if (rsp_valid !== 4'b0010 || rsp_err !== 1'b0 || rsp_dec !== 12'h000) begin n_fail++; $display("FAIL range_nocheck_rsp: got v=%b e=%b d=%h want 0010/0/000", rsp_valid, rsp_err, rsp_dec); end
`endif
        do_request(3, 999, rw, rdy, lat, st, sb);
        n_tests++; if (st !== 1'b1 || lat !== 7 || rsp_err !== 1'b0 || rsp_dec !== 12'h999) begin n_fail++; $display("FAIL range_edge_999: got start=%b lat=%0d e=%b d=%h want 1/7/0/999", st, lat, rsp_err, rsp_dec); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_timeout();
        test_coincide();
        test_reset_mid();
        test_range();
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
